// File: rtl/vxe_mem_req_arb_if.sv
// Shared memory request channel bundle: per-client FIFO-read side plus the
// single downstream address/write-data channel.
interface vxe_mem_req_arb_if #(
  parameter int NCLI = 4
);
  logic [NCLI-1:0]    i_rqa_vld;
  logic [NCLI*44-1:0] i_rqa;
  logic [NCLI-1:0]    o_rqa_rd;
  logic [NCLI-1:0]    i_rqd_vld;
  logic [NCLI*72-1:0] i_rqd;
  logic [NCLI-1:0]    o_rqd_rd;
  logic               i_rqa_rdy;
  logic [43:0]        o_rqa;
  logic               o_rqa_wr;
  logic               i_rqd_rdy;
  logic [71:0]        o_rqd;
  logic               o_rqd_wr;
  logic               o_busy;

  modport slave (
    input  i_rqa_vld, i_rqa, i_rqd_vld, i_rqd, i_rqa_rdy, i_rqd_rdy,
    output o_rqa_rd, o_rqd_rd, o_rqa, o_rqa_wr, o_rqd, o_rqd_wr, o_busy
  );

  modport master (
    output i_rqa_vld, i_rqa, i_rqd_vld, i_rqd, i_rqa_rdy, i_rqd_rdy,
    input  o_rqa_rd, o_rqd_rd, o_rqa, o_rqa_wr, o_rqd, o_rqd_wr, o_busy
  );
endinterface

// File: rtl/vxe_mem_req_arb.sv
// Round-robin arbiter sharing one memory request channel between NCLI clients;
// a write grant locks out other clients until its data beat has gone out.
// Optional per-client grant counters when VXE_MEM_REQ_ARB_STATS_EN is defined.
module vxe_mem_req_arb #(
  parameter int NCLI = 4,
  parameter int CW   = 2
) (
  input  logic                   clk,
  input  logic                   nrst,
  vxe_mem_req_arb_if.slave       bus
`ifdef VXE_MEM_REQ_ARB_STATS_EN
  ,
  input  logic                   i_stats_clr,
  output logic [NCLI*16-1:0]     o_grant_cnt
`endif
);
  localparam int AW = 44;
  localparam int DW = 72;

  typedef enum logic {ARB = 1'b0, WDAT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] lock_q, lock_d;
  logic          found;
  logic [CW-1:0] win;
  logic [CW-1:0] idx;
  logic [AW-1:0] win_rqa;

  // Search starts one past the last winner, so the last winner is lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= NCLI; i++) begin
      idx = CW'((int'(ptr_q) + i) % NCLI);
      if (!found && bus.i_rqa_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_rqa = bus.i_rqa[int'(win)*AW +: AW];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_d       = lock_q;
    bus.o_rqa_rd = '0;
    bus.o_rqa_wr = 1'b0;
    bus.o_rqa    = '0;
    bus.o_rqd_rd = '0;
    bus.o_rqd_wr = 1'b0;
    bus.o_rqd    = '0;
    case (state_q)
      ARB: begin
        if (found && bus.i_rqa_rdy) begin
          bus.o_rqa_rd[win] = 1'b1;
          bus.o_rqa_wr      = 1'b1;
          bus.o_rqa         = win_rqa;
          ptr_d             = win;
          if (win_rqa[43]) begin
            lock_d  = win;
            state_d = WDAT;
          end
        end
      end
      WDAT: begin
        // Only the locked client's beat may go; early data from others waits.
        if (bus.i_rqd_vld[lock_q] && bus.i_rqd_rdy) begin
          bus.o_rqd_rd[lock_q] = 1'b1;
          bus.o_rqd_wr         = 1'b1;
          bus.o_rqd            = bus.i_rqd[int'(lock_q)*DW +: DW];
          state_d              = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign bus.o_busy = (state_q == WDAT) || (|bus.i_rqa_vld);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ARB;
      ptr_q   <= CW'(NCLI - 1);
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

`ifdef VXE_MEM_REQ_ARB_STATS_EN
  for (genvar k = 0; k < NCLI; k++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                                      cnt_q <= '0;
      else if (i_stats_clr)                           cnt_q <= '0;
      else if (bus.o_rqa_rd[k] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign o_grant_cnt[k*16 +: 16] = cnt_q;
  end
`endif
endmodule
